trap_sched: RTL
===============

Name: trap_sched

Overview:
- Trap/interrupt scheduler for the machine-mode CSR unit.
- Arbitrates synchronous exceptions, MRET and the three machine interrupt sources (external, software, timer).
- Drains the pipeline before taking an interrupt, then issues a one-cycle CSR trap write (mepc/mcause/mtval) and a redirect to the handler or return address.
- Sits between the commit stage, the CSR register file and the fetch redirect path.

Parameters:
- XLEN, 64, datapath width.
- DRAIN_MAX, 15, max cycles in DRAIN before an interrupt is abandoned back to IDLE; counter width is clog2(DRAIN_MAX+1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- stall  in  1  pipeline stall; exc_valid and mret_valid are ignored while high
- mode  in  2  current privilege (3 = M)
- mstatus_mie  in  1  global M interrupt enable
- mie  in  XLEN  CSR mie
- mtvec  in  XLEN  CSR mtvec
- mepc  in  XLEN  CSR mepc
- irq_ext, irq_sw, irq_timer  in  1 each  level interrupt sources
- exc_valid  in  1  synchronous exception at commit
- exc_code  in  4  exception cause
- exc_pc  in  XLEN  faulting pc
- exc_tval  in  XLEN  trap value
- mret_valid  in  1  MRET at commit
- pipe_empty  in  1  no instruction in flight past decode
- commit_npc  in  XLEN  pc of next instruction to execute
- mip  out  XLEN  mip image: bit 11 = irq_ext, bit 3 = irq_sw, bit 7 = irq_timer, others 0 (combinational)
- hold_fetch  out  1  stop fetch/issue
- csr_trap_we  out  1  one-cycle CSR trap write strobe
- csr_mepc, csr_mcause, csr_mtval  out  XLEN each  trap write values
- csr_mret  out  1  one-cycle MRET strobe to the CSR unit
- redirect_valid  out  1  redirect request
- redirect_pc  out  XLEN  redirect target
- redirect_ready  in  1  fetch accepts redirect
- busy  out  1  state != IDLE

Behaviour:
- Reset: state = IDLE; all registered outputs and the latched cause/epc/tval = 0; drain counter = 0. Asserting reset in any state returns to IDLE immediately; a pending redirect is dropped.
- Pending interrupts: pend = mip & mie, gated by (mode != 3 || mstatus_mie).
- Interrupt priority: ext(11) > sw(3) > timer(7). Interrupt cause value = {1'b1, 59'b0, code}.
- States: IDLE, DRAIN, WRITE, REDIRECT. hold_fetch = 1 in every state except IDLE.
- IDLE, in priority order (first match wins):
  1. exc_valid & !stall: latch epc = exc_pc, cause = {0, exc_code}, tval = exc_tval; go to WRITE.
  2. mret_valid & !stall: pulse csr_mret; target = mepc; go to REDIRECT.
  3. pend != 0: latch the winning interrupt code; clear the drain counter; go to DRAIN.
- DRAIN:
  - exc_valid & !stall: exception preempts the interrupt (latch exception data, go to WRITE).
  - Else if pipe_empty: latch epc = commit_npc, tval = 0; go to WRITE.
  - Else if the interrupt is no longer pending, or the counter reaches DRAIN_MAX: go to IDLE with no CSR write.
  - Otherwise the counter increments by 1.
- WRITE (exactly one cycle): csr_trap_we = 1 with the latched csr_mepc/csr_mcause/csr_mtval; target = {mtvec[XLEN-1:2], 2'b00}; go to REDIRECT.
- REDIRECT: redirect_valid = 1 and redirect_pc = target, both stable until redirect_ready. On redirect_valid & redirect_ready, go to IDLE next cycle. New events arriving here are ignored.
- Latency:
  - Exception to csr_trap_we: 1 cycle.
  - Exception to redirect_valid: 2 cycles.
  - Interrupt with pipe_empty already high: 3 cycles to redirect_valid.
- Simultaneous events: exception beats MRET, MRET beats interrupt. An interrupt arriving in the same cycle as an exception stays pending and is re-evaluated in IDLE afterwards.

Optional Feature:
- TRAP_VECTORED_EN defined: for interrupts with mtvec[1:0] == 1, target = base + 4*code. Exceptions always go to base.
- TRAP_VECTORED_EN undefined: target is always base; mtvec[1:0] is ignored.

Test Plan:
- Exception: exc_valid=1, exc_code=2, exc_pc=0x80000010, mtvec=0x80001000 -> next cycle csr_trap_we=1, mcause=2, mepc=0x80000010; cycle after that redirect_pc=0x80001000. Hold redirect_ready=0 for 3 cycles -> redirect_pc stable.
- Timer interrupt: mie[7]=1, mstatus_mie=1, mode=3, irq_timer=1, pipe_empty rises after 4 cycles with commit_npc=0x80000200 -> mcause=0x8000000000000007, mepc=0x80000200.
- Priority: irq_ext=irq_sw=irq_timer=1 with all enabled -> mcause code 11. With exc_valid also high -> exception taken first, then interrupt 11 afterwards.
- Drain abort: pipe_empty held 0 for 20 cycles -> return to IDLE after DRAIN_MAX=15, no csr_trap_we. Separately, irq dropped mid-DRAIN -> return to IDLE.
- MRET: mepc=0x80000044, mret_valid=1 -> csr_mret pulse, redirect_pc=0x80000044. With stall=1 -> ignored.
- Vectored (TRAP_VECTORED_EN): mtvec=0x80001001, sw interrupt -> redirect_pc=0x8000100C. Assert reset in REDIRECT -> redirect_valid=0 immediately.

Source files
------------

// File: rtl/trap_sched_if.sv
// -----------------------------------------------------------------------------
// trap_sched_if
//   Bundles the outputs of the trap scheduler toward the CSR unit and the
//   fetch redirect handshake.
//
//   master (scheduler side):
//     csr_trap_we    out  one-cycle CSR trap write strobe
//     csr_mepc       out  mepc value to write
//     csr_mcause     out  mcause value to write
//     csr_mtval      out  mtval value to write
//     csr_mret       out  one-cycle MRET strobe
//     redirect_valid out  redirect request to fetch
//     redirect_pc    out  redirect target
//     redirect_ready in   fetch accepts the redirect
//   slave (CSR unit / fetch side): the same signals with directions reversed.
// -----------------------------------------------------------------------------
interface trap_sched_if #(
  parameter int XLEN = 64
);
  logic            csr_trap_we;
  logic [XLEN-1:0] csr_mepc;
  logic [XLEN-1:0] csr_mcause;
  logic [XLEN-1:0] csr_mtval;
  logic            csr_mret;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;

  modport master (
    output csr_trap_we, csr_mepc, csr_mcause, csr_mtval, csr_mret,
    output redirect_valid, redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  csr_trap_we, csr_mepc, csr_mcause, csr_mtval, csr_mret,
    input  redirect_valid, redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/trap_sched.sv
// -----------------------------------------------------------------------------
// trap_sched
//   Machine-mode trap/interrupt scheduler. Arbitrates synchronous exceptions,
//   MRET and the external/software/timer interrupts. Interrupts wait for the
//   pipeline to drain, then a one-cycle CSR trap write (mepc/mcause/mtval) is
//   issued followed by a redirect to the handler (or to mepc for MRET).
//
//   Optional feature macro: TRAP_VECTORED_EN
//     defined   : interrupts with mtvec[1:0] == 1 go to base + 4*code
//     undefined : every trap goes to base, mtvec[1:0] ignored
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   stall             blocks acceptance of exc_valid / mret_valid
//   mode              current privilege (3 = M)
//   mstatus_mie, mie  interrupt enables
//   mtvec, mepc       CSR values for trap entry / return
//   irq_ext/sw/timer  level interrupt sources
//   exc_valid/code/pc/tval  synchronous exception at commit
//   mret_valid        MRET at commit
//   pipe_empty        nothing in flight past decode
//   commit_npc        pc of next instruction (mepc for interrupts)
//   mip               combinational mip image
//   hold_fetch, busy  high whenever the scheduler is not idle
//   bus               CSR write strobes and fetch redirect handshake
// -----------------------------------------------------------------------------
module trap_sched #(
  parameter int XLEN      = 64,
  parameter int DRAIN_MAX = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [1:0]      mode,
  input  logic            mstatus_mie,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            irq_ext,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic            exc_valid,
  input  logic [3:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_valid,
  input  logic            pipe_empty,
  input  logic [XLEN-1:0] commit_npc,
  output logic [XLEN-1:0] mip,
  output logic            hold_fetch,
  output logic            busy,
  trap_sched_if.master    bus
);

  localparam int CNT_W = $clog2(DRAIN_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DRAIN_MAX);

  typedef enum logic [1:0] {IDLE, DRAIN, WRITE, REDIRECT} state_t;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]      code_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] tval_q;
  logic [XLEN-1:0] tgt_q;
  logic            we_q;
  logic            mret_q;
  logic            rv_q;

  logic            int_en;
  logic [XLEN-1:0] pend;
  logic            exc_go;
  logic            mret_go;

  // Fixed priority: external > software > timer.
  function automatic logic [3:0] irq_code(input logic e, input logic s);
    if (e)      return 4'd11;
    else if (s) return 4'd3;
    else        return 4'd7;
  endfunction

  function automatic logic [XLEN-1:0] irq_cause(input logic [3:0] c);
    return {1'b1, {(XLEN-5){1'b0}}, c};
  endfunction

  // Masking the mode bits keeps every mtvec bit referenced in both builds.
`ifdef TRAP_VECTORED_EN
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] tvec,
                                                  input logic [XLEN-1:0] cause);
    logic [XLEN-1:0] base;
    base = tvec & ~{{(XLEN-2){1'b0}}, 2'b11};
    if (cause[XLEN-1] && (tvec[1:0] == 2'b01))
      return base + {{(XLEN-6){1'b0}}, cause[3:0], 2'b00};
    else
      return base;
  endfunction
`else
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] tvec);
    return tvec & ~{{(XLEN-2){1'b0}}, 2'b11};
  endfunction
`endif

  assign mip     = XLEN'({irq_ext, 3'b000, irq_timer, 3'b000, irq_sw, 3'b000});
  assign int_en  = (mode != 2'd3) || mstatus_mie;
  assign pend    = mip & mie & {XLEN{int_en}};
  assign exc_go  = exc_valid & ~stall;
  assign mret_go = mret_valid & ~stall;

  assign busy       = (state != IDLE);
  assign hold_fetch = (state != IDLE);

  assign bus.csr_trap_we    = we_q;
  assign bus.csr_mepc       = epc_q;
  assign bus.csr_mcause     = cause_q;
  assign bus.csr_mtval      = tval_q;
  assign bus.csr_mret       = mret_q;
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = tgt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      code_q  <= '0;
      epc_q   <= '0;
      cause_q <= '0;
      tval_q  <= '0;
      tgt_q   <= '0;
      we_q    <= 1'b0;
      mret_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      we_q   <= 1'b0;
      mret_q <= 1'b0;
      case (state)
        IDLE: begin
          if (exc_go) begin
            epc_q   <= exc_pc;
            cause_q <= {{(XLEN-4){1'b0}}, exc_code};
            tval_q  <= exc_tval;
            we_q    <= 1'b1;
            state   <= WRITE;
          end else if (mret_go) begin
            mret_q <= 1'b1;
            tgt_q  <= mepc;
            rv_q   <= 1'b1;
            state  <= REDIRECT;
          end else if (|pend) begin
            code_q  <= irq_code(pend[11], pend[3]);
            cause_q <= irq_cause(irq_code(pend[11], pend[3]));
            cnt     <= '0;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          // A committing exception overrides the interrupt being drained for.
          if (exc_go) begin
            epc_q   <= exc_pc;
            cause_q <= {{(XLEN-4){1'b0}}, exc_code};
            tval_q  <= exc_tval;
            we_q    <= 1'b1;
            state   <= WRITE;
          end else if (pipe_empty) begin
            epc_q  <= commit_npc;
            tval_q <= '0;
            we_q   <= 1'b1;
            state  <= WRITE;
          end else if (!pend[code_q] || (cnt == CNT_MAX)) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WRITE: begin
`ifdef TRAP_VECTORED_EN
          tgt_q <= trap_target(mtvec, cause_q);
`else
          tgt_q <= trap_target(mtvec);
`endif
          rv_q  <= 1'b1;
          state <= REDIRECT;
        end
        REDIRECT: begin
          if (bus.redirect_ready) begin
            rv_q  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
